lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage_pkg.sv | 40 ++++
 rtl/lsu_stage_if.sv | 47 ++++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_stage.sv | 137 +++++++++++++
 tb/tb_lsu_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_stage_pkg.sv
// Shared constants for the load/store stage: data width, FSM encodings,
// RV64I load/store funct3 codes and the byte-lane size mask helper.
package lsu_stage_pkg;

    localparam int unsigned XLEN = 64;

    // FSM state encodings
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Load funct3 codes
    localparam logic [2:0] LsuLb  = 3'b000;
    localparam logic [2:0] LsuLh  = 3'b001;
    localparam logic [2:0] LsuLw  = 3'b010;
    localparam logic [2:0] LsuLd  = 3'b011;
    localparam logic [2:0] LsuLbu = 3'b100;
    localparam logic [2:0] LsuLhu = 3'b101;
    localparam logic [2:0] LsuLwu = 3'b110;

    // Store funct3 codes
    localparam logic [2:0] LsuSb  = 3'b000;
    localparam logic [2:0] LsuSh  = 3'b001;
    localparam logic [2:0] LsuSw  = 3'b010;
    localparam logic [2:0] LsuSd  = 3'b011;

    // Byte-lane mask for an access of 1, 2, 4 or 8 bytes (funct3[1:0])
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Bundle of the stage's execute-side, memory-side and writeback-side handshakes.
interface lsu_stage_if;
    import lsu_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            is_load;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wstrb;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            out_fault;

    // The stage itself
    modport slave (
        input  in_valid, is_load, is_store, funct3, addr, store_data,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output out_valid, out_data, out_fault,
        input  out_ready
    );

    // The surrounding pipeline and memory
    modport master (
        output in_valid, is_load, is_store, funct3, addr, store_data,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  out_valid, out_data, out_fault,
        output out_ready
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store data/strobe alignment, load extraction with
// sign/zero extension, and misalignment / illegal-funct3 fault detection.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      off_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [7:0]      wstrb_o,
    output logic [XLEN-1:0] ldata_o,
    output logic            fault_o
);

    logic            misalign;
    logic            illegal;
    logic [XLEN-1:0] shifted;

    // Fault detection and store lane placement
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = off_i[0];
            2'b10:   misalign = |off_i[1:0];
            default: misalign = |off_i;
        endcase
        illegal = (is_load_i && funct3_i == 3'b111) || (is_store_i && funct3_i[2]);
        fault_o = (is_load_i || is_store_i) && (misalign || illegal);
        wdata_o = store_data_i << {off_i, 3'b000};
        wstrb_o = size_mask(funct3_i[1:0]) << off_i;
    end

    // Load extraction: move the addressed byte to lane 0, then extend
    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            LsuLb:   ldata_o = {{56{shifted[7]}}, shifted[7:0]};
            LsuLh:   ldata_o = {{48{shifted[15]}}, shifted[15:0]};
            LsuLw:   ldata_o = {{32{shifted[31]}}, shifted[31:0]};
            LsuLbu:  ldata_o = {56'd0, shifted[7:0]};
            LsuLhu:  ldata_o = {48'd0, shifted[15:0]};
            LsuLwu:  ldata_o = {32'd0, shifted[31:0]};
            default: ldata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Single-outstanding load/store stage: accepts one op, issues at most one
// memory request, waits for grant (and read data for loads), then holds the
// result until the writeback side takes it.
module lsu_stage
    import lsu_stage_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    lsu_stage_if.slave  bus
);

    logic [1:0]      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [2:0]      off_q, off_d;
    logic            is_load_q, is_load_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]      mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_fault_q, out_fault_d;

    logic            idle;
    logic [XLEN-1:0] al_wdata;
    logic [7:0]      al_wstrb;
    logic [XLEN-1:0] al_ldata;
    logic            al_fault;

    assign idle = (state_q == StIdle);

    // One aligner serves both phases: in IDLE it sees the incoming op (store
    // lanes, fault), afterwards the captured op (load extraction in RESP).
    lsu_align u_align (
        .is_load_i    (idle ? bus.is_load : is_load_q),
        .is_store_i   (idle ? bus.is_store : 1'b0),
        .funct3_i     (idle ? bus.funct3 : funct3_q),
        .off_i        (idle ? bus.addr[2:0] : off_q),
        .store_data_i (bus.store_data),
        .rdata_i      (bus.mem_rdata),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .ldata_o      (al_ldata),
        .fault_o      (al_fault)
    );

    // Next-state and capture logic
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        out_data_d  = out_data_q;
        out_fault_d = out_fault_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    funct3_d    = bus.funct3;
                    off_d       = bus.addr[2:0];
                    is_load_d   = bus.is_load;
                    out_data_d  = '0;
                    out_fault_d = 1'b0;
                    if (!(bus.is_load || bus.is_store)) begin
                        out_data_d = bus.addr;
                        state_d    = StDone;
                    end else if (al_fault) begin
                        out_fault_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        mem_addr_d  = {bus.addr[XLEN-1:3], 3'b000};
                        mem_we_d    = !bus.is_load;
                        mem_wdata_d = bus.is_load ? '0 : al_wdata;
                        mem_wstrb_d = bus.is_load ? 8'h00 : al_wstrb;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.mem_gnt) begin
                    state_d = is_load_q ? StResp : StDone;
                end
            end
            StResp: begin
                if (bus.mem_rvalid) begin
                    out_data_d = al_ldata;
                    state_d    = StDone;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State and datapath registers; reset abandons any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            funct3_q    <= '0;
            off_q       <= '0;
            is_load_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            out_data_q  <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            out_data_q  <= out_data_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign bus.in_ready  = idle;
    assign bus.mem_req   = (state_q == StReq);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = out_data_q;
    assign bus.out_fault = out_fault_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: expected results are queued when an op is
// driven and popped when the stage presents its result.
module tb_lsu_stage;
    import lsu_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_stage_if bus ();

    lsu_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Drive one op, play memory with the given grant delay, hold out_ready low
    // for rdy_wait cycles, then retire it against the scoreboard.
    task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sd,
                          input logic [63:0] rdata, input int gnt_wait, input int rdy_wait,
                          input logic exp_fault, input logic [63:0] exp_data,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
        exp_t e;
        logic mem_op;
        mem_op = (ld || st) && !exp_fault;
        @(negedge clk);
        check_val({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid   = 1'b1;
        bus.is_load    = ld;
        bus.is_store   = st;
        bus.funct3     = f3;
        bus.addr       = addr;
        bus.store_data = sd;
        e.data  = exp_data;
        e.fault = exp_fault;
        sb_q.push_back(e);
        @(negedge clk);
        // scramble inputs so only captured values can produce the result
        bus.in_valid   = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.funct3     = ~f3;
        bus.addr       = ~addr;
        bus.store_data = ~sd;
        if (mem_op) begin
            for (int i = 0; i <= gnt_wait; i++) begin
                check_val({tag, ".mem_req"}, 64'(bus.mem_req), 64'd1);
                check_val({tag, ".mem_addr"}, bus.mem_addr, addr & ~64'h7);
                check_val({tag, ".mem_we"}, 64'(bus.mem_we), 64'(st));
                check_val({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
                check_val({tag, ".mem_wstrb"}, 64'(bus.mem_wstrb), 64'(exp_wstrb));
                check_val({tag, ".busy_valid"}, 64'(bus.out_valid), 64'd0);
                check_val({tag, ".busy_ready"}, 64'(bus.in_ready), 64'd0);
                if (i == gnt_wait) begin
                    // rvalid in the grant cycle carries junk and must be ignored
                    bus.mem_gnt    = 1'b1;
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = ~rdata;
                end
                @(negedge clk);
            end
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (ld) begin
                check_val({tag, ".resp_req"}, 64'(bus.mem_req), 64'd0);
                check_val({tag, ".resp_valid"}, 64'(bus.out_valid), 64'd0);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
                @(negedge clk);
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end
        end
        check_val({tag, ".done_req"}, 64'(bus.mem_req), 64'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            check_val({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_val({tag, ".hold_ready"}, 64'(bus.in_ready), 64'd0);
            check_val({tag, ".hold_data"}, bus.out_data, exp_data);
            @(negedge clk);
        end
        check_val({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, ".out_data"}, bus.out_data, e.data);
            check_val({tag, ".out_fault"}, 64'(bus.out_fault), 64'(e.fault));
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, ".retired"}, 64'(bus.out_valid), 64'd0);
        check_val({tag, ".reaccept"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.funct3     = '0;
        bus.addr       = '0;
        bus.store_data = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.out_ready  = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_val("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst.mem_req", 64'(bus.mem_req), 64'd0);
        check_val("rst.mem_we", 64'(bus.mem_we), 64'd0);
        check_val("rst.mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        check_val("rst.out_data", bus.out_data, 64'd0);
        check_val("rst.out_fault", 64'(bus.out_fault), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     tag     ld    st    f3      addr                   store_data             rdata                  gw rw flt  exp_data               exp_wdata              wstrb
        run_op("sd",   1'b0, 1'b1, 3'b011, 64'h1000,              64'h1122334455667788,  64'h0,                 0, 0, 1'b0, 64'h0,                 64'h1122334455667788,  8'hFF);
        run_op("alu",  1'b0, 1'b0, 3'b000, 64'hDEADBEEFCAFEF00D,  64'h0,                 64'h0,                 0, 1, 1'b0, 64'hDEADBEEFCAFEF00D,  64'h0,                 8'h00);
        run_op("lwmis",1'b1, 1'b0, 3'b010, 64'h1002,              64'h0,                 64'h0,                 0, 0, 1'b1, 64'h0,                 64'h0,                 8'h00);
        // lane 2 holds 0xFF, lane 3 holds 0x80
        run_op("lb2",  1'b1, 1'b0, 3'b000, 64'h1002,              64'h0,                 64'h0000000080FF0000,  0, 0, 1'b0, 64'hFFFFFFFFFFFFFFFF,  64'h0,                 8'h00);
        run_op("lbu2", 1'b1, 1'b0, 3'b100, 64'h1002,              64'h0,                 64'h0000000080FF0000,  0, 0, 1'b0, 64'h00000000000000FF,  64'h0,                 8'h00);
        run_op("lb3",  1'b1, 1'b0, 3'b000, 64'h1003,              64'h0,                 64'h0000000080FF0000,  0, 0, 1'b0, 64'hFFFFFFFFFFFFFF80,  64'h0,                 8'h00);
        run_op("lbu3", 1'b1, 1'b0, 3'b100, 64'h1003,              64'h0,                 64'h0000000080FF0000,  0, 0, 1'b0, 64'h0000000000000080,  64'h0,                 8'h00);
        run_op("sh",   1'b0, 1'b1, 3'b001, 64'h2006,              64'hABCD,              64'h0,                 0, 0, 1'b0, 64'h0,                 64'hABCD000000000000,  8'hC0);
        run_op("swst", 1'b0, 1'b1, 3'b010, 64'h3004,              64'h12345678,          64'h0,                 5, 3, 1'b0, 64'h0,                 64'h1234567800000000,  8'hF0);
        run_op("sb",   1'b0, 1'b1, 3'b000, 64'h1005,              64'hA5,                64'h0,                 0, 0, 1'b0, 64'h0,                 64'h0000A50000000000,  8'h20);
        run_op("lh",   1'b1, 1'b0, 3'b001, 64'h100A,              64'h0,                 64'h0000000080010000,  0, 0, 1'b0, 64'hFFFFFFFFFFFF8001,  64'h0,                 8'h00);
        run_op("lhu",  1'b1, 1'b0, 3'b101, 64'h100A,              64'h0,                 64'h0000000080010000,  1, 0, 1'b0, 64'h0000000000008001,  64'h0,                 8'h00);
        run_op("lw",   1'b1, 1'b0, 3'b010, 64'h1004,              64'h0,                 64'h89ABCDEF00000000,  2, 1, 1'b0, 64'hFFFFFFFF89ABCDEF,  64'h0,                 8'h00);
        run_op("lwu",  1'b1, 1'b0, 3'b110, 64'h1004,              64'h0,                 64'h89ABCDEF00000000,  0, 0, 1'b0, 64'h0000000089ABCDEF,  64'h0,                 8'h00);
        run_op("ld",   1'b1, 1'b0, 3'b011, 64'h1008,              64'h0,                 64'h0123456789ABCDEF,  0, 2, 1'b0, 64'h0123456789ABCDEF,  64'h0,                 8'h00);
        run_op("alu2", 1'b0, 1'b0, 3'b011, 64'h5555000000000001,  64'h0,                 64'h0,                 0, 0, 1'b0, 64'h5555000000000001,  64'h0,                 8'h00);
        run_op("ld111",1'b1, 1'b0, 3'b111, 64'h1000,              64'h0,                 64'h0,                 0, 0, 1'b1, 64'h0,                 64'h0,                 8'h00);
        run_op("st100",1'b0, 1'b1, 3'b100, 64'h1000,              64'h77,                64'h0,                 0, 0, 1'b1, 64'h0,                 64'h0,                 8'h00);
        run_op("shmis",1'b0, 1'b1, 3'b001, 64'h2001,              64'h1,                 64'h0,                 0, 0, 1'b1, 64'h0,                 64'h0,                 8'h00);
        run_op("sdmis",1'b0, 1'b1, 3'b011, 64'h1004,              64'h1,                 64'h0,                 0, 1, 1'b1, 64'h0,                 64'h0,                 8'h00);

        // Reset taken in RESP, followed by a late rvalid
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.is_load  = 1'b1;
        bus.funct3   = 3'b011;
        bus.addr     = 64'h4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.is_load  = 1'b0;
        check_val("rr.in_req", 64'(bus.mem_req), 64'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rr.valid", 64'(bus.out_valid), 64'd0);
        check_val("rr.req", 64'(bus.mem_req), 64'd0);
        check_val("rr.ready", 64'(bus.in_ready), 64'd1);
        check_val("rr.addr", bus.mem_addr, 64'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hFEEDFACE12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_val("rr.late_valid", 64'(bus.out_valid), 64'd0);
        check_val("rr.late_ready", 64'(bus.in_ready), 64'd1);
        check_val("rr.late_data", bus.out_data, 64'd0);
        run_op("post", 1'b1, 1'b0, 3'b010, 64'h4004, 64'h0, 64'h7FFFFFFF00000000, 0, 0, 1'b0,
               64'h000000007FFFFFFF, 64'h0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
